regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 register file between two writeback
//  sources: ALU results and memory loads. Uses valid/ready arbitration with a
//  round-robin pointer, and drives Write_Register/Write_Data/RegWrite to the file
//  registered, with 1-cycle latency. Keeps a busy scoreboard of registers with a
//  write pending, so the decode stage can stall on RAW and WAW hazards.
// PARAMETERS
//  DATA_W  32  width of write data
//  ADDR_W  5   register index width
//  NREG    32  number of registers (2**ADDR_W); reg 0 is hardwired zero
// PORTS
//  Clock           in   1       rising-edge clock
//  Reset           in   1       synchronous, active-high reset
//  alu_valid       in   1       ALU writeback request
//  alu_rd          in   ADDR_W  ALU destination register
//  alu_data        in   DATA_W  ALU result
//  alu_ready       out  1       ALU request accepted this cycle (combinational)
//  mem_valid       in   1       load writeback request
//  mem_rd          in   ADDR_W  load destination register
//  mem_data        in   DATA_W  load data
//  mem_ready       out  1       load request accepted this cycle (combinational)
//  issue_valid     in   1       decode issues an instruction that writes issue_rd
//  issue_rd        in   ADDR_W  destination of the issuing instruction
//  issue_ready     out  1       issue allowed: !busy[issue_rd] (comb.)
//  rs1, rs2        in   ADDR_W  source registers of the instruction in decode
//  raw_stall       out  1       (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) (comb.)
//  RegWrite        out  1       write enable to the register file (registered)
//  Write_Register  out  ADDR_W  write index (registered)
//  Write_Data      out  DATA_W  write data (registered)
// BEHAVIOUR
//  - Reset values: RegWrite=0, Write_Register=0, Write_Data=0, busy=0, pointer=ALU.
//  - Reset asserted mid-operation: requests in flight are dropped, and outputs are
//    at reset values on the next cycle.
//  - Handshake:
//    - A transfer occurs when valid & ready are both high at the rising edge.
//    - A requester holds rd/data stable while valid & !ready.
//    - ready never depends on data.
//  - Arbitration: at most one grant per cycle.
//    - Only one source valid: it is granted.
//    - Both valid: the source named by the pointer is granted.
//    - After any grant, the pointer moves to the non-granted source.
//  - Latency: a grant at edge N drives RegWrite=1, Write_Register=rd and
//    Write_Data=data for cycle N..N+1. The register file writes at edge N+1.
//  - Cycle with no grant: RegWrite=0. Write_Register and Write_Data hold their
//    last value.
//  - rd==0: the handshake completes normally (ready=1 if granted), but RegWrite
//    stays 0, and the pointer still advances.
//  - Scoreboard:
//    - issue_valid & issue_ready & issue_rd!=0 sets busy[issue_rd] at the edge.
//    - The edge ending a cycle with RegWrite=1 clears busy[Write_Register].
//    - Set and clear of the same register at the same edge: set wins.
//    - busy[0] is always 0.
//  - issue_ready uses registered busy only; there is no same-cycle clear bypass.
//    issue_rd==0 is always ready.
//  - raw_stall also uses registered busy only; the decode stage rereads after
//    the write edge.
// TESTING
//  1. Reset: hold Reset 2 cycles with both sources valid -> RegWrite=0, busy=0,
//     no grant recorded; pointer=ALU after release.
//  2. ALU only: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1. Next cycle
//     RegWrite=1, Write_Register=5, Write_Data=0xDEADBEEF; the cycle after,
//     RegWrite=0.
//  3. Contention: both valid for 4 cycles (alu rd=1, mem rd=2) -> grants go
//     ALU,MEM,ALU,MEM; the loser has ready=0 and holds its request.
//  4. rd=0: mem_valid, mem_rd=0, data=0x1234 -> mem_ready=1, RegWrite stays 0,
//     busy unchanged.
//  5. Scoreboard: issue rd=7 -> busy[7]=1; rs1=7 gives raw_stall=1 and
//     issue_rd=7 gives issue_ready=0. After the ALU writes rd=7, busy[7]=0 the
//     cycle after RegWrite, and raw_stall=0.
//  6. Set/clear collision: issue rd=9 on the same edge that RegWrite=1 with
//     Write_Register=9 -> busy[9]=1 after the edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue and register-file-write signals shared by the pipeline
// (master) and the writeback arbiter (slave).
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;

  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              raw_stall;

  logic              RegWrite;
  logic [ADDR_W-1:0] Write_Register;
  logic [DATA_W-1:0] Write_Data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1, rs2,
    input  raw_stall,
    input  RegWrite, Write_Register, Write_Data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1, rs2,
    output raw_stall,
    output RegWrite, Write_Register, Write_Data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port (ALU vs. load) with a
// busy scoreboard that lets decode stall on pending writes.
//
//  state   | meaning
//  PTR_ALU | ALU wins the next contended cycle
//  PTR_MEM | load wins the next contended cycle
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  regfile_wb_arbiter_if.slave   bus
);

  typedef enum logic {PTR_ALU = 1'b0, PTR_MEM = 1'b1} ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic              alu_gnt, mem_gnt;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              issue_set;

  always_ff @(posedge Clock) begin
    if (Reset) ptr_q <= PTR_ALU;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (alu_gnt)      ptr_d = PTR_MEM;
    else if (mem_gnt) ptr_d = PTR_ALU;
  end

  // No handshake completes while Reset is held, so nothing is recorded.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!Reset) begin
      alu_gnt = bus.alu_valid & (~bus.mem_valid | (ptr_q == PTR_ALU));
      mem_gnt = bus.mem_valid & (~bus.alu_valid | (ptr_q == PTR_MEM));
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;

  always_comb begin
    sel_rd      = alu_gnt ? bus.alu_rd   : bus.mem_rd;
    sel_data    = alu_gnt ? bus.alu_data : bus.mem_data;
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (alu_gnt | mem_gnt) begin
      reg_write_d = (sel_rd != '0);
      wr_reg_d    = sel_rd;
      wr_data_d   = sel_data;
    end
  end

  assign issue_set = bus.issue_valid & bus.issue_ready & (bus.issue_rd != '0);

  // Clear first so a same-edge issue to the register being written wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) busy_d[wr_reg_q] = 1'b0;
    if (issue_set)   busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.issue_ready    = ~busy_q[bus.issue_rd];
  assign bus.raw_stall      = ((bus.rs1 != '0) & busy_q[bus.rs1]) |
                              ((bus.rs2 != '0) & busy_q[bus.rs2]);
  assign bus.RegWrite       = reg_write_q;
  assign bus.Write_Register = wr_reg_q;
  assign bus.Write_Data     = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of the writeback arbiter against a
// cycle-level reference model of grants, writes and the busy set.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(32)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_busy [32];
  bit          m_pref_mem;
  bit          m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  bit          g_alu, g_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic cycle();
    bit a, m, iss, stall;
    a = bus.alu_valid;
    m = bus.mem_valid;
    #1;
    g_alu = !Reset && a && (!m || !m_pref_mem);
    g_mem = !Reset && m && (!a || m_pref_mem);
    if (!Reset) begin
      stall = (bus.rs1 != 0 && m_busy[bus.rs1]) || (bus.rs2 != 0 && m_busy[bus.rs2]);
      chk("alu_ready", bus.alu_ready, g_alu);
      chk("mem_ready", bus.mem_ready, g_mem);
      chk("issue_ready", bus.issue_ready, !m_busy[bus.issue_rd]);
      chk("raw_stall", bus.raw_stall, stall);
    end
    @(posedge Clock);
    if (Reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_pref_mem = 1'b0;
      m_we = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      iss = bus.issue_valid && bus.issue_rd != 0 && !m_busy[bus.issue_rd];
      if (m_we) m_busy[m_wr] = 1'b0;
      if (iss)  m_busy[bus.issue_rd] = 1'b1;
      if (g_alu) begin
        m_we = (bus.alu_rd != 0); m_wr = bus.alu_rd; m_wd = bus.alu_data; m_pref_mem = 1'b1;
      end else if (g_mem) begin
        m_we = (bus.mem_rd != 0); m_wr = bus.mem_rd; m_wd = bus.mem_data; m_pref_mem = 1'b0;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    chk("RegWrite", bus.RegWrite, m_we);
    if (m_we) begin
      chk("Write_Register", bus.Write_Register, m_wr);
      chk("Write_Data", bus.Write_Data, m_wd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAAAA0003;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hBBBB0004;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;

    // 1. Reset held two cycles with both sources requesting
    cycle();
    cycle();
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i);
      #1;
      chk("reset_busy", bus.raw_stall, 1'b0);
    end
    bus.rs1 = '0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    cycle();
    chk("reset_regwrite", bus.RegWrite, 1'b0);

    // 3. Contention: first grant goes to ALU, then alternates
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("contend_alu_ready", bus.alu_ready, (k % 2) == 0);
      chk("contend_mem_ready", bus.mem_ready, (k % 2) == 1);
      cycle();
      chk("contend_wr", bus.Write_Register, ((k % 2) == 0) ? 32'd1 : 32'd2);
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;

    // 2. ALU only, then the write drops and the write port holds
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_only_ready", bus.alu_ready, 1'b1);
    cycle();
    chk("alu_only_we", bus.RegWrite, 1'b1);
    chk("alu_only_wr", bus.Write_Register, 32'd5);
    chk("alu_only_wd", bus.Write_Data, 32'hDEADBEEF);
    bus.alu_valid = 1'b0;
    cycle();
    chk("idle_we", bus.RegWrite, 1'b0);
    chk("idle_hold_wr", bus.Write_Register, 32'd5);
    chk("idle_hold_wd", bus.Write_Data, 32'hDEADBEEF);

    // 4. Load to r0 completes the handshake without a write
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h1234;
    #1;
    chk("r0_ready", bus.mem_ready, 1'b1);
    cycle();
    chk("r0_we", bus.RegWrite, 1'b0);
    bus.mem_valid = 1'b0;
    bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    cycle();
    chk("r0_busy", bus.raw_stall, 1'b0);

    // 5. Scoreboard set by issue, cleared by the write
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    cycle();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd7; bus.rs2 = 5'd0;
    #1;
    chk("sb_stall", bus.raw_stall, 1'b1);
    chk("sb_issue_ready", bus.issue_ready, 1'b0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    cycle();
    chk("sb_write_we", bus.RegWrite, 1'b1);
    bus.alu_valid = 1'b0;
    cycle();
    #1;
    chk("sb_cleared", bus.raw_stall, 1'b0);
    chk("sb_issue_free", bus.issue_ready, 1'b1);

    // 6. Issue and write-clear of r9 on the same edge
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    bus.issue_rd = 5'd0;
    cycle();
    chk("coll_we", bus.RegWrite, 1'b1);
    chk("coll_wr", bus.Write_Register, 32'd9);
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cycle();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd9;
    #1;
    chk("coll_set_wins", bus.raw_stall, 1'b1);
    cycle();
    chk("coll_still_busy", bus.raw_stall, 1'b1);

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 500; i++) begin
      Reset = ($urandom_range(0, 79) == 0);
      if (!bus.alu_valid || g_alu) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 5'($urandom_range(0, 7));
        bus.alu_data  = $urandom;
      end
      if (!bus.mem_valid || g_mem) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = 5'($urandom_range(0, 7));
        bus.mem_data  = $urandom;
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1         = 5'($urandom_range(0, 7));
      bus.rs2         = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
